ascon_fsm_ctrl: RTL and testbench

- Sequencing controller for the ASCON-128a permutation datapath (state mux, xor up, constant addition, substitution, linear diffusion, xor down, state register).
- Drives round counter, register enable, input-mux select and both XOR stages through a full AEAD encryption: initialisation, associated data (AD), plaintext (P), finalisation.
- Owns the block-level valid/ready handshake with the data source, and flags ciphertext and tag availability to the top level.

---
 rtl/ascon_fsm_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_ascon_fsm_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_fsm_ctrl.sv
// ascon_fsm_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for an ASCON-128a permutation datapath. It walks a
// full AEAD encryption (initialisation, associated data, plaintext,
// finalisation), driving the round constant index, the state register enable,
// the input-mux select and both XOR stages. It also owns the block-level
// valid/ready handshake with the data source and flags ciphertext and tag
// availability.
//
// Ports:
//   clock_i         clock
//   reset_i         asynchronous active-low reset
//   start_i         start one encryption (sampled in IDLE or DONE only)
//   block_valid_i   AD or P block present on the datapath data input
//   block_ready_o   controller accepts a block this cycle
//   round_o         round constant index (4 bits)
//   enable_o        state register write enable
//   sel_mux_o       0 = load external initial state, 1 = loop back register
//   ena_xor_up_o    xor data input into the rate
//   key_up_o        finalisation key injection on the first FIN cycle
//   ena_xor_down_o  xor down enable
//   sel_xor_down_o  00 key into S3,S4 / 01 domain separator / 10 key + dom.sep
//   block_type_o    0 = AD, 1 = P (meaningful while block_ready_o is high)
//   cipher_valid_o  rate after xor up is ciphertext this cycle
//   tag_valid_o     register S3,S4 holds the tag
//   done_o          encryption complete
// ----------------------------------------------------------------------------
module ascon_fsm_ctrl #(
   parameter int NB_AD    = 1,
   parameter int NB_P     = 4,
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 8
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       block_valid_i,
   output logic       block_ready_o,
   output logic [3:0] round_o,
   output logic       enable_o,
   output logic       sel_mux_o,
   output logic       ena_xor_up_o,
   output logic       key_up_o,
   output logic       ena_xor_down_o,
   output logic [1:0] sel_xor_down_o,
   output logic       block_type_o,
   output logic       cipher_valid_o,
   output logic       tag_valid_o,
   output logic       done_o
);

   // Every phase ends on round 11; shorter phases simply start later.
   localparam logic [3:0] LAST_RND = 4'd11;
   localparam logic [3:0] RA_FIRST = 4'(12 - ROUNDS_A);
   localparam logic [3:0] RB_FIRST = 4'(12 - ROUNDS_B);

   localparam int AD_W = (NB_AD < 2) ? 1 : $clog2(NB_AD + 1);
   localparam int P_W  = (NB_P  < 2) ? 1 : $clog2(NB_P + 1);

   localparam logic             HAS_AD  = (NB_AD > 0);
   localparam logic [AD_W-1:0]  AD_LAST = HAS_AD ? AD_W'(NB_AD - 1) : '0;
   localparam logic [P_W-1:0]   P_LAST  = P_W'(NB_P - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_WAIT_AD,
      S_AD,
      S_WAIT_P,
      S_PT,
      S_FIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        round_q, round_d;
   logic [AD_W-1:0]   ad_cnt_q, ad_cnt_d;
   logic [P_W-1:0]    p_cnt_q, p_cnt_d;
   logic              fin_seen_q;   // previous cycle was FIN -> first DONE cycle
   logic              last_rnd;

   assign last_rnd = (round_q == LAST_RND);

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= S_IDLE;
         round_q    <= '0;
         ad_cnt_q   <= '0;
         p_cnt_q    <= '0;
         fin_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         ad_cnt_q   <= ad_cnt_d;
         p_cnt_q    <= p_cnt_d;
         fin_seen_q <= (state_q == S_FIN);
      end
   end

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      ad_cnt_d       = ad_cnt_q;
      p_cnt_d        = p_cnt_q;
      block_ready_o  = 1'b0;
      round_o        = '0;
      enable_o       = 1'b0;
      sel_mux_o      = 1'b0;
      ena_xor_up_o   = 1'b0;
      key_up_o       = 1'b0;
      ena_xor_down_o = 1'b0;
      sel_xor_down_o = 2'b00;
      block_type_o   = 1'b0;
      cipher_valid_o = 1'b0;
      tag_valid_o    = 1'b0;
      done_o         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_INIT;
               round_d  = RA_FIRST;
               ad_cnt_d = '0;
               p_cnt_d  = '0;
            end
         end

         S_INIT: begin
            enable_o  = 1'b1;
            round_o   = round_q;
            // Only the very first round loads the external initial state.
            sel_mux_o = (round_q != RA_FIRST);
            if (last_rnd) begin
               ena_xor_down_o = 1'b1;
               // Without AD the domain separator is folded into the key xor.
               sel_xor_down_o = HAS_AD ? 2'b00 : 2'b10;
               state_d        = HAS_AD ? S_WAIT_AD : S_WAIT_P;
            end else begin
               round_d = round_q + 4'd1;
            end
         end

         S_WAIT_AD: begin
            block_ready_o = 1'b1;
            block_type_o  = 1'b0;
            if (block_valid_i) begin
               state_d = S_AD;
               round_d = RB_FIRST;
            end
         end

         S_AD: begin
            enable_o     = 1'b1;
            sel_mux_o    = 1'b1;
            round_o      = round_q;
            ena_xor_up_o = (round_q == RB_FIRST);
            if (last_rnd) begin
               ad_cnt_d = ad_cnt_q + AD_W'(1);
               if (ad_cnt_q == AD_LAST) begin
                  ena_xor_down_o = 1'b1;
                  sel_xor_down_o = 2'b01;
                  state_d        = S_WAIT_P;
               end else begin
                  state_d = S_WAIT_AD;
               end
            end else begin
               round_d = round_q + 4'd1;
            end
         end

         S_WAIT_P: begin
            block_ready_o = 1'b1;
            block_type_o  = 1'b1;
            if (block_valid_i) begin
               // The last plaintext block is absorbed by the FIN phase itself.
               if (p_cnt_q == P_LAST) begin
                  state_d = S_FIN;
                  round_d = RA_FIRST;
               end else begin
                  state_d = S_PT;
                  round_d = RB_FIRST;
               end
            end
         end

         S_PT: begin
            enable_o       = 1'b1;
            sel_mux_o      = 1'b1;
            round_o        = round_q;
            ena_xor_up_o   = (round_q == RB_FIRST);
            cipher_valid_o = (round_q == RB_FIRST);
            if (last_rnd) begin
               p_cnt_d = p_cnt_q + P_W'(1);
               state_d = S_WAIT_P;
            end else begin
               round_d = round_q + 4'd1;
            end
         end

         S_FIN: begin
            enable_o       = 1'b1;
            sel_mux_o      = 1'b1;
            round_o        = round_q;
            ena_xor_up_o   = (round_q == RA_FIRST);
            key_up_o       = (round_q == RA_FIRST);
            cipher_valid_o = (round_q == RA_FIRST);
            if (last_rnd) begin
               ena_xor_down_o = 1'b1;
               sel_xor_down_o = 2'b00;
               state_d        = S_DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end

         S_DONE: begin
            done_o      = 1'b1;
            tag_valid_o = fin_seen_q;
            if (start_i) begin
               state_d  = S_INIT;
               round_d  = RA_FIRST;
               ad_cnt_d = '0;
               p_cnt_d  = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// tb_ascon_fsm_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for ascon_fsm_ctrl. A default-parameter instance is
// driven from a cycle table; a second instance with NB_AD=0 covers the
// no-associated-data path. Hand-written sequences cover stalls, ignored
// start, restart from DONE and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_ascon_fsm_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start, valid;
   logic start1, valid1;

   // Default instance outputs
   logic       ready, en, smux, xu, key, xd, bt, cv, tag, done;
   logic [3:0] rnd;
   logic [1:0] sx;

   // NB_AD = 0 instance outputs
   logic       ready1, en1, smux1, xu1, key1, xd1, bt1, cv1, tag1, done1;
   logic [3:0] rnd1;
   logic [1:0] sx1;

   ascon_fsm_ctrl #(.NB_AD(1), .NB_P(4), .ROUNDS_A(12), .ROUNDS_B(8)) u_dut (
      .clock_i        (clk),
      .reset_i        (rst_n),
      .start_i        (start),
      .block_valid_i  (valid),
      .block_ready_o  (ready),
      .round_o        (rnd),
      .enable_o       (en),
      .sel_mux_o      (smux),
      .ena_xor_up_o   (xu),
      .key_up_o       (key),
      .ena_xor_down_o (xd),
      .sel_xor_down_o (sx),
      .block_type_o   (bt),
      .cipher_valid_o (cv),
      .tag_valid_o    (tag),
      .done_o         (done)
   );

   ascon_fsm_ctrl #(.NB_AD(0), .NB_P(4), .ROUNDS_A(12), .ROUNDS_B(8)) u_dut_nad (
      .clock_i        (clk),
      .reset_i        (rst_n),
      .start_i        (start1),
      .block_valid_i  (valid1),
      .block_ready_o  (ready1),
      .round_o        (rnd1),
      .enable_o       (en1),
      .sel_mux_o      (smux1),
      .ena_xor_up_o   (xu1),
      .key_up_o       (key1),
      .ena_xor_down_o (xd1),
      .sel_xor_down_o (sx1),
      .block_type_o   (bt1),
      .cipher_valid_o (cv1),
      .tag_valid_o    (tag1),
      .done_o         (done1)
   );

   // {round, en, smux, xu, key, xd, sx[1:0], ready, bt, cv, tag, done}
   logic [15:0] obs;
   assign obs = {rnd, en, smux, xu, key, xd, sx, ready, bt, cv, tag, done};

   typedef struct {
      logic        start;
      logic        valid;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic s, input logic v, input logic [3:0] r,
                       input logic e, input logic sm, input logic u, input logic k,
                       input logic d, input logic [1:0] x, input logic rd,
                       input logic b, input logic c, input logic t, input logic dn);
      vec_t rec;
      rec.start = s;
      rec.valid = v;
      rec.exp   = {r, e, sm, u, k, d, x, rd, b, c, t, dn};
      tbl.push_back(rec);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int cv_cnt;
      int tagn;
      logic saw_ad;
      logic [3:0] frozen;

      // Expected cycle table: default parameters, start pulse, valid held 1.
      push(1, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);             // IDLE accepts start
      for (int r = 0; r < 12; r++)                                          // INIT
         push(0, 1, 4'(r), 1, (r != 0), 0, 0, (r == 11), 2'b00, 0, 0, 0, 0, 0);
      push(0, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0);             // WAIT_AD
      for (int r = 4; r < 12; r++)                                          // AD (last block)
         push(0, 1, 4'(r), 1, 1, (r == 4), 0, (r == 11),
              (r == 11) ? 2'b01 : 2'b00, 0, 0, 0, 0, 0);
      for (int b = 0; b < 3; b++) begin
         push(0, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0);          // WAIT_P
         for (int r = 4; r < 12; r++)                                       // PT
            push(0, 1, 4'(r), 1, 1, (r == 4), 0, 0, 2'b00, 0, 0, (r == 4), 0, 0);
      end
      push(0, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0);             // WAIT_P last
      for (int r = 0; r < 12; r++)                                          // FIN
         push(0, 1, 4'(r), 1, 1, (r == 0), (r == 0), (r == 11), 2'b00, 0, 0, (r == 0), 0, 0);
      push(0, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1);             // DONE, cycle 62
      push(0, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
      push(0, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);

      rst_n  = 1'b0;
      start  = 1'b0;
      valid  = 1'b0;
      start1 = 1'b0;
      valid1 = 1'b0;
      #1;
      check("reset_outputs", obs, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("idle_outputs", obs, 16'h0000);

      // Table-driven full encryption
      cv_cnt = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         start = tbl[i].start;
         valid = tbl[i].valid;
         #1;
         check($sformatf("vec%0d", i), obs, tbl[i].exp);
         if (cv) cv_cnt++;
      end
      check("cipher_valid_count", cv_cnt, 4);

      // Restart from DONE, then stall in WAIT_P
      @(negedge clk);
      start = 1'b1;
      valid = 1'b0;
      #1;
      check("done_before_restart", done, 1);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("restart_init", {rnd, en, smux, done}, {4'd0, 1'b1, 1'b0, 1'b0});
      n = 0;
      while (!(ready && !bt) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("reach_wait_ad", {ready, bt}, 2'b10);
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      #1;
      check("ad_first", {rnd, en, xu, cv}, {4'd4, 1'b1, 1'b1, 1'b0});
      n = 0;
      while (!(ready && bt) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("reach_wait_p", {ready, bt}, 2'b11);
      frozen = rnd;
      for (int k = 0; k < 5; k++) begin
         check("stall_ready", ready, 1);
         check("stall_enable", en, 0);
         check("stall_round", rnd, frozen);
         @(negedge clk); #1;
      end
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      start = 1'b1;                       // start during PT must be ignored
      #1;
      check("pt_first", {rnd, en, xu, cv}, {4'd4, 1'b1, 1'b1, 1'b1});
      cv_cnt = 1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("start_ignored_pt", {rnd, en, smux, done}, {4'd5, 1'b1, 1'b1, 1'b0});
      valid = 1'b1;
      n = 0;
      while (!tag && n < 200) begin
         @(negedge clk); #1; n++;
         if (cv) cv_cnt++;
      end
      check("rerun_tag", tag, 1);
      check("rerun_cipher_count", cv_cnt, 4);

      // Asynchronous reset in the middle of the AD phase
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      n = 0;
      while (!(en && xu && !cv) && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("reach_ad", {en, xu, cv}, 3'b110);
      @(negedge clk);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", obs, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_idle", obs, 16'h0000);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("post_reset_init", {rnd, en, smux}, {4'd0, 1'b1, 1'b0});

      // NB_AD = 0 instance
      @(negedge clk);
      start1 = 1'b1;
      valid1 = 1'b1;
      saw_ad = 1'b0;
      tagn   = -1;
      #1;
      for (int k = 0; k < 80; k++) begin
         if (k > 0) begin
            @(negedge clk); #1;
         end
         if (k == 1) start1 = 1'b0;
         if (ready1 && !bt1) saw_ad = 1'b1;
         if (k == 12)
            check("nad_init_r11", {rnd1, en1, xd1, sx1}, {4'd11, 1'b1, 1'b1, 2'b10});
         if (tag1 && tagn < 0) tagn = k;
      end
      check("nad_no_ad_handshake", saw_ad, 0);
      check("nad_tag_latency", tagn, 53);
      check("nad_done_held", done1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
